// File: rtl/ysyx_22050243_exec_seq.sv
// Multi-cycle execution sequencer: steps each decoded instruction through
// execute, optional data-memory access and write-back, halting on ebreak or memory timeout.
module ysyx_22050243_exec_seq #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [2:0]  mem2reg,
    input  logic        reg_w,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic        branch,
    input  logic        csr_r,
    input  logic [1:0]  pc_src_ctrl,
    input  logic        is_ebreak,
    input  logic        branch_taken,
    output logic        mem_req_valid,
    output logic        mem_req_wr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    output logic        rf_we,
    output logic [2:0]  rf_wsel,
    output logic        csr_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        commit,
    output logic [63:0] instret,
    output logic        halted,
    output logic        halt_code
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MEM_REQ,
        MEM_WAIT,
        WB,
        HALT
    } state_t;

    // Counter only needs to reach MEM_TIMEOUT; a zero limit keeps a 1-bit dummy.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    state_t          state;
    state_t          state_nx;
    logic [2:0]      mem2reg_q;
    logic            reg_w_q;
    logic            mem_r_q;
    logic            mem_w_q;
    logic            branch_q;
    logic            csr_r_q;
    logic [1:0]      pc_src_ctrl_q;
    logic            taken_q;
    logic [CW-1:0]   wait_cnt;
    logic            halt_code_q;
    logic            timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == LIMIT);

    always_comb begin
        state_nx      = state;
        inst_ready    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_wr    = 1'b0;
        rf_we         = 1'b0;
        csr_we        = 1'b0;
        pc_we         = 1'b0;
        commit        = 1'b0;
        pc_sel        = 2'b00;
        halted        = 1'b0;
        case (state)
            IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid) begin
                    state_nx = is_ebreak ? HALT : EXEC;
                end
            end
            EXEC: begin
                state_nx = (mem_r_q | mem_w_q) ? MEM_REQ : WB;
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_wr    = mem_w_q;
                // A handshake on the limit cycle still completes the access.
                if (mem_req_ready) begin
                    state_nx = mem_w_q ? WB : MEM_WAIT;
                end else if (timeout_hit) begin
                    state_nx = HALT;
                end
            end
            MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    state_nx = WB;
                end else if (timeout_hit) begin
                    state_nx = HALT;
                end
            end
            WB: begin
                rf_we    = reg_w_q;
                csr_we   = csr_r_q;
                pc_we    = 1'b1;
                commit   = 1'b1;
                state_nx = IDLE;
                if (pc_src_ctrl_q == 2'b01) begin
                    pc_sel = 2'b01;
                end else if (pc_src_ctrl_q == 2'b10) begin
                    pc_sel = 2'b10;
                end else if (branch_q && taken_q) begin
                    pc_sel = 2'b01;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign rf_wsel   = mem2reg_q;
    assign halt_code = halt_code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mem2reg_q     <= 3'b000;
            reg_w_q       <= 1'b0;
            mem_r_q       <= 1'b0;
            mem_w_q       <= 1'b0;
            branch_q      <= 1'b0;
            csr_r_q       <= 1'b0;
            pc_src_ctrl_q <= 2'b00;
            taken_q       <= 1'b0;
            wait_cnt      <= '0;
            instret       <= 64'd0;
            halt_code_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && inst_valid) begin
                mem2reg_q     <= mem2reg;
                reg_w_q       <= reg_w;
                mem_r_q       <= mem_r;
                mem_w_q       <= mem_w;
                branch_q      <= branch;
                csr_r_q       <= csr_r;
                pc_src_ctrl_q <= pc_src_ctrl;
            end
            if (state == EXEC) begin
                taken_q <= branch_taken;
            end
            if ((state_nx != state) && (state_nx == MEM_REQ || state_nx == MEM_WAIT)) begin
                wait_cnt <= '0;
            end else if (state == MEM_REQ || state == MEM_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == WB) begin
                instret <= instret + 64'd1;
            end
            // Halting straight from IDLE can only be ebreak; any other path is a timeout.
            if (state != HALT && state_nx == HALT) begin
                halt_code_q <= (state != IDLE);
            end
        end
    end

endmodule
